// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges the dcache 256-bit line port to 64-bit, 4-beat
// memory bursts. One refill or writeback is in flight at a time.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_BURST = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [LINE_W-1:0]  r_wline;
  logic [LINE_W-1:0]  r_line;
  logic               r_bmem_read;
  logic               r_bmem_write;
  logic [BEAT_W-1:0]  r_bmem_wdata;
  logic               r_dfp_resp;

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BEAT_W-1:0]  w_next_beat;
  logic               w_beat_hit;
  logic [31:0]        w_line_addr;

  // The low five address bits select a byte inside the line and are masked off.
  assign w_line_addr = dfp_addr & 32'hFFFF_FFE0;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_next_beat = r_wline[w_cnt_nxt*BEAT_W +: BEAT_W];
  assign w_beat_hit  = bmem_rvalid && (bmem_raddr == r_addr);

  assign dfp_rdata  = r_line;
  assign dfp_resp   = r_dfp_resp;
  assign bmem_addr  = r_addr;
  assign bmem_read  = r_bmem_read;
  assign bmem_write = r_bmem_write;
  assign bmem_wdata = r_bmem_wdata;

  // Burst sequencing FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= 32'h0000_0000;
      r_wline      <= '0;
      r_line       <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
      r_dfp_resp   <= 1'b0;
    end else begin
      r_dfp_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (dfp_write) begin
            // Writeback wins over a simultaneous refill; the refill is picked up
            // afterwards because dcache keeps dfp_read asserted.
            r_state      <= S_WR_BURST;
            r_addr       <= w_line_addr;
            r_wline      <= dfp_wdata;
            r_bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            r_bmem_write <= 1'b1;
          end else if (dfp_read) begin
            r_state     <= S_RD_REQ;
            r_addr      <= w_line_addr;
            r_bmem_read <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_state     <= S_RD_WAIT;
          end else begin
            r_bmem_read <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (w_beat_hit) begin
            r_line[r_cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
            if (r_cnt == LAST_BEAT) begin
              r_cnt      <= '0;
              r_state    <= S_RESP;
              r_dfp_resp <= 1'b1;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_WR_BURST: begin
          // Only beat 0 waits for ready; later beats stream back-to-back.
          if ((r_cnt != '0) || bmem_ready) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt        <= '0;
              r_bmem_write <= 1'b0;
              r_bmem_wdata <= '0;
              r_state      <= S_RESP;
              r_dfp_resp   <= 1'b1;
            end else begin
              r_cnt        <= w_cnt_nxt;
              r_bmem_wdata <= w_next_beat;
            end
          end else begin
            r_bmem_write <= 1'b1;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt        <= '0;
          r_bmem_read  <= 1'b0;
          r_bmem_write <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed testbench for cacheline_adapter: refill, writeback, backpressure,
// gapped/stray beats, write-before-read priority and mid-burst reset.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;
  int n_rd_acc = 0;

  localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] GP_LINE = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                      64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  // Count completion pulses and accepted read commands at the sampling edge.
  always @(posedge clk) begin
    if (rst === 1'b1 && dfp_resp === 1'b1) n_resp <= n_resp + 1;
    if (rst === 1'b1 && bmem_read === 1'b1 && bmem_ready === 1'b1) n_rd_acc <= n_rd_acc + 1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_raddr  = a;
    bmem_rdata  = d;
    tick();
    bmem_rvalid = 1'b0;
    bmem_raddr  = 32'h0;
    bmem_rdata  = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL rst_resp: got %b want 0", dfp_resp); end
    n_cmp++; if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rst_bmem_read: got %b want 0", bmem_read); end
    n_cmp++; if (bmem_write !== 1'b0) begin n_err++; $display("FAIL rst_bmem_write: got %b want 0", bmem_write); end
    n_cmp++; if (bmem_addr !== 32'h0) begin n_err++; $display("FAIL rst_bmem_addr: got %h want 0", bmem_addr); end
    n_cmp++; if (bmem_wdata !== 64'h0) begin n_err++; $display("FAIL rst_bmem_wdata: got %h want 0", bmem_wdata); end
    n_cmp++; if (dfp_rdata !== 256'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", dfp_rdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int r0;
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    n_cmp++; if (bmem_read !== 1'b1) begin n_err++; $display("FAIL rd_cmd: got %b want 1", bmem_read); end
    n_cmp++; if (bmem_addr !== 32'h0000_1220) begin n_err++; $display("FAIL rd_addr: got %h want 00001220", bmem_addr); end
    tick();
    n_cmp++; if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rd_cmd_pulse: got %b want 0", bmem_read); end
    send_beat(32'h0000_1220, 64'h1111_1111_1111_1111);
    send_beat(32'h0000_1220, 64'h2222_2222_2222_2222);
    send_beat(32'h0000_1220, 64'h3333_3333_3333_3333);
    n_cmp++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL rd_early_resp: got %b want 0", dfp_resp); end
    send_beat(32'h0000_1220, 64'h4444_4444_4444_4444);
    n_cmp++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL rd_resp: got %b want 1", dfp_resp); end
    n_cmp++; if (dfp_rdata !== RD_LINE) begin n_err++; $display("FAIL rd_line: got %h want %h", dfp_rdata, RD_LINE); end
    r0 = n_resp;
    dfp_read = 1'b0;
    tick();
    tick();
    n_cmp++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL rd_resp_len: got %b want 0", dfp_resp); end
    n_cmp++; if (n_resp - r0 !== 1) begin n_err++; $display("FAIL rd_resp_count: got %0d want 1", n_resp - r0); end
    n_cmp++; if (dfp_rdata !== RD_LINE) begin n_err++; $display("FAIL rd_line_hold: got %h want %h", dfp_rdata, RD_LINE); end
  endtask

  task automatic test_write();
    logic [63:0] beats[4];
    int wcyc[4];
    int nw, cyc, resp_cyc;
    beats[0] = 64'hA0A1_A2A3_A4A5_A6A7; beats[1] = 64'hB0B1_B2B3_B4B5_B6B7;
    beats[2] = 64'hC0C1_C2C3_C4C5_C6C7; beats[3] = 64'hD0D1_D2D3_D4D5_D6D7;
    dfp_wdata = {beats[3], beats[2], beats[1], beats[0]};
    dfp_addr = 32'h0000_5678; dfp_write = 1'b1; bmem_ready = 1'b1;
    nw = 0; cyc = 1; resp_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cyc++;
      if (bmem_write === 1'b1) begin
        if (nw < 4) begin
          n_cmp++;
          if (bmem_wdata !== beats[nw]) begin n_err++; $display("FAIL wr_beat%0d: got %h want %h", nw, bmem_wdata, beats[nw]); end
          n_cmp++;
          if (bmem_addr !== 32'h0000_5660) begin n_err++; $display("FAIL wr_addr: got %h want 00005660", bmem_addr); end
          wcyc[nw] = cyc;
        end
        nw++;
      end
      if (dfp_resp === 1'b1) begin
        resp_cyc = cyc;
        dfp_write = 1'b0;
        break;
      end
    end
    n_cmp++; if (nw !== 4) begin n_err++; $display("FAIL wr_beat_count: got %0d want 4", nw); end
    n_cmp++; if (nw == 4 && wcyc[0] !== 2 || nw == 4 && wcyc[3] !== 5) begin n_err++; $display("FAIL wr_beat_cycles: got %0d..%0d want 2..5", wcyc[0], wcyc[3]); end
    n_cmp++; if (resp_cyc !== 6) begin n_err++; $display("FAIL wr_resp_cycle: got %0d want 6", resp_cyc); end
    dfp_write = 1'b0;
    tick();
    n_cmp++; if (dfp_resp !== 1'b0 || bmem_write !== 1'b0) begin n_err++; $display("FAIL wr_after: got resp=%b write=%b want 0 0", dfp_resp, bmem_write); end
    n_cmp++; if (dfp_rdata !== RD_LINE) begin n_err++; $display("FAIL wr_rdata_hold: got %h want %h", dfp_rdata, RD_LINE); end
  endtask

  task automatic test_backpressure();
    int n0, hi;
    logic [255:0] exp_line;
    exp_line = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    n0 = n_rd_acc; hi = 0;
    dfp_addr = 32'h0000_2040; dfp_read = 1'b1; bmem_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (bmem_read === 1'b1) hi++;
      tick();
    end
    n_cmp++; if (hi !== 5) begin n_err++; $display("FAIL bp_read_held: got %0d want 5", hi); end
    n_cmp++; if (bmem_read !== 1'b1) begin n_err++; $display("FAIL bp_read_still: got %b want 1", bmem_read); end
    bmem_ready = 1'b1;
    tick();
    n_cmp++; if (bmem_read !== 1'b0) begin n_err++; $display("FAIL bp_read_drop: got %b want 0", bmem_read); end
    send_beat(32'h0000_2040, 64'h9999_0000_0000_0001);
    send_beat(32'h0000_2040, 64'h9999_0000_0000_0002);
    send_beat(32'h0000_2040, 64'h9999_0000_0000_0003);
    send_beat(32'h0000_2040, 64'h9999_0000_0000_0004);
    n_cmp++; if (dfp_resp !== 1'b1 || dfp_rdata !== exp_line) begin n_err++; $display("FAIL bp_line: got resp=%b %h want 1 %h", dfp_resp, dfp_rdata, exp_line); end
    dfp_read = 1'b0;
    tick();
    tick();
    n_cmp++; if (n_rd_acc - n0 !== 1) begin n_err++; $display("FAIL bp_accept_count: got %0d want 1", n_rd_acc - n0); end
  endtask

  task automatic test_gapped();
    int r0;
    r0 = n_resp;
    dfp_addr = 32'h0000_3000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    // Matching beat before the command is accepted: must be ignored.
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_3000; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bmem_rvalid = 1'b0;
    send_beat(32'h0000_3000, 64'h5555_5555_5555_5555);
    send_beat(32'h0000_3020, 64'hDEAD_DEAD_DEAD_DEAD);
    tick();
    send_beat(32'h0000_3000, 64'h6666_6666_6666_6666);
    tick(); tick();
    send_beat(32'h0000_3000, 64'h7777_7777_7777_7777);
    n_cmp++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL gap_early_resp: got %b want 0", dfp_resp); end
    tick(); tick();
    n_cmp++; if (n_resp !== r0) begin n_err++; $display("FAIL gap_no_resp_yet: got %0d want %0d", n_resp, r0); end
    send_beat(32'h0000_3000, 64'h8888_8888_8888_8888);
    n_cmp++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL gap_resp: got %b want 1", dfp_resp); end
    n_cmp++; if (dfp_rdata !== GP_LINE) begin n_err++; $display("FAIL gap_line: got %h want %h", dfp_rdata, GP_LINE); end
    dfp_read = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int wb, got, rd_early, seen;
    logic [255:0] exp_line;
    exp_line = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    wb = 0; got = 0; rd_early = 0; seen = 0;
    dfp_addr = 32'h0000_7000; dfp_wdata = {4{64'h0123_4567_89AB_CDEF}};
    dfp_read = 1'b1; dfp_write = 1'b1; bmem_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bmem_read === 1'b1) rd_early = 1;
      if (bmem_write === 1'b1) wb++;
      if (dfp_resp === 1'b1) begin
        got = 1;
        dfp_write = 1'b0;
        break;
      end
    end
    n_cmp++; if (got !== 1) begin n_err++; $display("FAIL both_wr_resp: got %0d want 1", got); end
    n_cmp++; if (wb !== 4) begin n_err++; $display("FAIL both_wr_beats: got %0d want 4", wb); end
    n_cmp++; if (rd_early !== 0) begin n_err++; $display("FAIL both_order: got read_before_write=%0d want 0", rd_early); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bmem_read === 1'b1) begin seen = 1; break; end
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL both_rd_cmd: got %0d want 1", seen); end
    tick();
    send_beat(32'h0000_7000, 64'hE0E0_E0E0_E0E0_E0E0);
    send_beat(32'h0000_7000, 64'hE1E1_E1E1_E1E1_E1E1);
    send_beat(32'h0000_7000, 64'hE2E2_E2E2_E2E2_E2E2);
    send_beat(32'h0000_7000, 64'hE3E3_E3E3_E3E3_E3E3);
    n_cmp++; if (dfp_resp !== 1'b1 || dfp_rdata !== exp_line) begin n_err++; $display("FAIL both_rd_line: got resp=%b %h want 1 %h", dfp_resp, dfp_rdata, exp_line); end
    dfp_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [255:0] exp_line;
    exp_line = {64'hF3F3_0000_0000_0003, 64'hF2F2_0000_0000_0002,
                64'hF1F1_0000_0000_0001, 64'hF0F0_0000_0000_0000};
    dfp_addr = 32'h0000_5000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    tick();
    send_beat(32'h0000_5000, 64'hC0C0_C0C0_C0C0_C0C0);
    send_beat(32'h0000_5000, 64'hC1C1_C1C1_C1C1_C1C1);
    send_beat(32'h0000_5000, 64'hC2C2_C2C2_C2C2_C2C2);
    r0 = n_resp;
    rst = 1'b0; dfp_read = 1'b0;
    tick();
    n_cmp++; if (dfp_resp !== 1'b0 || bmem_read !== 1'b0 || bmem_write !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got resp=%b rd=%b wr=%b want 0 0 0", dfp_resp, bmem_read, bmem_write); end
    n_cmp++; if (bmem_addr !== 32'h0 || dfp_rdata !== 256'h0) begin n_err++; $display("FAIL mid_rst_data: got addr=%h rdata=%h want 0", bmem_addr, dfp_rdata); end
    rst = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (n_resp !== r0) begin n_err++; $display("FAIL mid_rst_no_resp: got %0d want %0d", n_resp, r0); end
    dfp_addr = 32'h0000_601F; dfp_read = 1'b1;
    tick();
    n_cmp++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_6000) begin n_err++; $display("FAIL post_rst_cmd: got rd=%b addr=%h want 1 00006000", bmem_read, bmem_addr); end
    tick();
    send_beat(32'h0000_6000, 64'hF0F0_0000_0000_0000);
    send_beat(32'h0000_6000, 64'hF1F1_0000_0000_0001);
    send_beat(32'h0000_6000, 64'hF2F2_0000_0000_0002);
    send_beat(32'h0000_6000, 64'hF3F3_0000_0000_0003);
    n_cmp++; if (dfp_resp !== 1'b1 || dfp_rdata !== exp_line) begin n_err++; $display("FAIL post_rst_line: got resp=%b %h want 1 %h", dfp_resp, dfp_rdata, exp_line); end
    dfp_read = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; dfp_addr = 32'h0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = 256'h0;
    bmem_ready = 1'b0; bmem_raddr = 32'h0; bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
